sa_multi_stream_gen: RTL and testbench
======================================

// Module: sa_multi_stream_gen
// PURPOSE
//  Multi-channel Streaming-Accurate (SA) bitstream generator for the unary decompressor datapath.
//  CH independent lanes produce one bitstream each, in lock-step. Lane c encodes k[c]/2^N.
//  Each lane uses an overflow accumulator, so 1s are spread evenly and partial streams stay accurate.
//  Adds to the single-lane generator: programmable stream length, start/busy/done control,
//  valid/ready output with backpressure, and a per-stream init mode (SA midpoint or zero).
// PARAMETERS
//  N   7  accumulator/value width; max stream length L = 2^N
//  CH  4  number of parallel lanes
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous, active-low reset
//  start      in   1       begin a new stream; honoured only in IDLE
//  mode       in   1       0 = SA (acc init L/2), 1 = zero-init; captured at start
//  len        in   N+1     number of beats, 0..2^N; captured at start
//  k          in   CH*N    lane c value in k[c*N +: N]; captured at start
//  busy       out  1       high while in RUN
//  out_valid  out  1       bit vector x_out is valid
//  out_ready  in   1       consumer accepts the beat
//  x_out      out  CH      one stream bit per lane
//  done       out  1       one-cycle pulse when the stream completes
//  ones_cnt   out  CH*(N+1) per-lane count of emitted 1s (only with SA_ONES_CNT_EN)
// BEHAVIOUR
//  Reset values:
//  - state = IDLE; all acc = 2^(N-1); k_reg = 0; beat_cnt = 0.
//  - busy = 0, out_valid = 0, done = 0; ones_cnt = 0.
//  FSM states: IDLE, RUN, FIN.
//  IDLE:
//  - start=1 and len != 0: latch k, mode and len; acc[c] = mode ? 0 : 2^(N-1); beat_cnt = 0;
//    go to RUN next cycle.
//  - start=1 and len == 0: go to FIN; no beats are emitted.
//  RUN:
//  - busy = 1 and out_valid = 1.
//  - x_out[c] = carry(acc[c] + k_reg[c]). This is combinational from registers, so it stays
//    stable while out_ready = 0.
//  - A beat transfers when out_valid & out_ready. On a transfer:
//    acc[c] <= (acc[c] + k_reg[c]) mod 2^N; beat_cnt <= beat_cnt + 1.
//  - Transfer with beat_cnt == len_reg-1: go to FIN.
//  - out_ready = 0: all state holds. Stall length is unbounded.
//  FIN:
//  - done = 1 for exactly one cycle, then IDLE. out_valid = 0.
//  - In FIN, acc and ones_cnt hold their final values.
//  Latency:
//  - start to first valid beat: 1 cycle.
//  - A len-beat stream with no stalls occupies len cycles in RUN, plus 1 cycle in FIN.
//  - Back-to-back streams: start may be asserted in the cycle done is high, but it is ignored.
//    It is accepted on the next IDLE cycle.
//  Boundary conditions:
//  - start outside IDLE is ignored. k, mode and len changes mid-stream have no effect.
//  - k = 0: all-zero stream. k = 2^N-1 in SA mode, len = 2^N: exactly 2^N-1 ones.
//  - len = 2^N (MSB set) is legal; beat_cnt is N+1 bits wide.
//  - rst_n low mid-stream: the stream is aborted, all reset values apply next cycle, and no done pulse.
//  - Accumulator wrap is modulo 2^N; the carry out is the only output source.
// CONFIGURATION
//  SA_ONES_CNT_EN defined:
//  - Each lane keeps an (N+1)-bit counter of transferred 1s.
//  - The counter clears at accepted start and holds after FIN.
//  - It drives ones_cnt and is used for on-line accuracy checks.
//  SA_ONES_CNT_EN undefined:
//  - No counters are built; ones_cnt is tied to 0.
// STRUCTURE
//  Shared package sa_pkg:
//  - FSM state encoding (IDLE/RUN/FIN).
//  - Mode constants SA_MODE_MID = 0, SA_MODE_ZERO = 1.
//  - Helper for midpoint 2^(N-1).
//  Sub-module sa_acc_lane (one per lane, generate loop). It holds acc, k_reg and the optional
//  ones counter, with ports load, init_zero, adv, k_in, bit_out, ones.
//  The top level holds the FSM, beat_cnt, len_reg and the handshake.
// TESTING
//  - N=3, CH=1, mode=0, k=3, len=8, out_ready=1
//    -> x_out beats 0,1,0,1,0,0,1,0; done pulses 1 cycle after the last beat.
//  - N=3, mode=1, k=3, len=8 -> beats 0,0,1,0,0,1,0,1.
//  - N=3, CH=4, mode=0, k={0,7,4,1}, len=8
//    -> per-lane ones = 0,7,4,1; lane k=4 gives 1,0,1,0,1,0,1,0.
//  - Toggle out_ready 0/1 randomly during the k=3 SA stream
//    -> same bit sequence; x_out stable while stalled; beat count 8.
//  - len=0 at start -> no valid beats, done 1 cycle later.
//    start during RUN -> ignored; beat_cnt is unaffected.
//  - rst_n low for 1 cycle after 3 beats
//    -> busy=0, out_valid=0, no done pulse; a new start then restarts from L/2.
//  - With SA_ONES_CNT_EN: k=5, SA mode, len=4 (N=3) -> ones_cnt = 3 (bits 1,0,1,1).

Source files
------------

// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the Streaming-Accurate (SA) multi-lane bitstream
// generator: FSM state encoding, init-mode constants and the accumulator
// midpoint helper.
// -----------------------------------------------------------------------------
package sa_pkg;

  // Generator control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } sa_state_e;

  // Accumulator init modes, captured at start
  localparam logic SA_MODE_MID  = 1'b0;  // acc starts at L/2
  localparam logic SA_MODE_ZERO = 1'b1;  // acc starts at 0

  // Midpoint 2^(n-1) of an n-bit accumulator
  function automatic int unsigned sa_mid(input int unsigned n);
    return 32'd1 << (n - 32'd1);
  endfunction

endpackage

// File: rtl/sa_acc_lane.sv
// -----------------------------------------------------------------------------
// sa_acc_lane
// One SA lane: overflow accumulator plus the latched lane value. The emitted
// stream bit is the carry out of acc + k_reg, so the 1s are spread evenly.
// Optional feature macro: SA_ONES_CNT_EN (per-lane count of transferred 1s).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        capture k_in and initialise acc (start accepted)
//   init_zero   1: acc starts at 0, 0: acc starts at 2^(N-1)
//   adv         a beat was transferred; step the accumulator
//   k_in        lane value (N bits)
//   bit_out     current stream bit (combinational from registers)
//   ones        count of transferred 1s, or 0 without SA_ONES_CNT_EN
// -----------------------------------------------------------------------------
module sa_acc_lane
  import sa_pkg::*;
#(
  parameter int unsigned N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         init_zero,
  input  logic         adv,
  input  logic [N-1:0] k_in,
  output logic         bit_out,
  output logic [N:0]   ones
);

  localparam logic [N-1:0] MID = N'(sa_mid(N));

  logic [N-1:0] acc_r;
  logic [N-1:0] k_r;
  logic [N:0]   sum_s;

  // The MSB of the widened sum is the carry; the low N bits are the wrapped acc.
  assign sum_s   = {1'b0, acc_r} + {1'b0, k_r};
  assign bit_out = sum_s[N];

  // Accumulator and latched lane value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= MID;
      k_r   <= {N{1'b0}};
    end else if (load) begin
      acc_r <= init_zero ? {N{1'b0}} : MID;
      k_r   <= k_in;
    end else if (adv) begin
      acc_r <= sum_s[N-1:0];
      k_r   <= k_r;
    end else begin
      acc_r <= acc_r;
      k_r   <= k_r;
    end
  end

`ifdef SA_ONES_CNT_EN
  logic [N:0] ones_r;

  // Count of 1s actually handed to the consumer; at most 2^N so N+1 bits suffice
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_r <= {(N+1){1'b0}};
    end else if (load) begin
      ones_r <= {(N+1){1'b0}};
    end else if (adv) begin
      ones_r <= ones_r + {{N{1'b0}}, bit_out};
    end else begin
      ones_r <= ones_r;
    end
  end

  assign ones = ones_r;
`else
  assign ones = {(N+1){1'b0}};
`endif

endmodule

// File: rtl/sa_multi_stream_gen.sv
// -----------------------------------------------------------------------------
// sa_multi_stream_gen
// CH-lane Streaming-Accurate bitstream generator. Lane c encodes k[c]/2^N as a
// len-beat stream delivered over a valid/ready handshake, lanes in lock-step.
// Optional feature macro: SA_ONES_CNT_EN (drives ones_cnt; otherwise tied 0).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (aborts a stream, no done)
//   start       begin a stream; honoured only in IDLE
//   mode        0 = SA midpoint init, 1 = zero init; captured at start
//   len         beats per stream, 0..2^N; captured at start
//   k           lane c value in k[c*N +: N]; captured at start
//   busy        high while streaming
//   out_valid   x_out holds a beat
//   out_ready   consumer accepts the beat
//   x_out       one stream bit per lane
//   done        one-cycle pulse after the last beat (or for len = 0)
//   ones_cnt    per-lane count of transferred 1s, (N+1) bits per lane
// -----------------------------------------------------------------------------
module sa_multi_stream_gen
  import sa_pkg::*;
#(
  parameter int unsigned N  = 7,
  parameter int unsigned CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [N:0]        len,
  input  logic [CH*N-1:0]   k,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH-1:0]     x_out,
  output logic              done,
  output logic [CH*(N+1)-1:0] ones_cnt
);

  sa_state_e  state_r;
  sa_state_e  state_n;
  logic [N:0] beat_cnt_r;
  logic [N:0] len_r;
  logic       busy_r;
  logic       valid_r;
  logic       done_r;
  logic       load_s;
  logic       adv_s;
  logic       last_s;
  logic       init_zero_s;

  assign init_zero_s = (mode == SA_MODE_ZERO);
  // len_r is never 0 in RUN, so len_r - 1 does not underflow there.
  assign last_s      = (beat_cnt_r == (len_r - {{N{1'b0}}, 1'b1}));

  // Next-state, lane load and beat-advance decode
  always_comb begin
    state_n = state_r;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len != {(N+1){1'b0}}) begin
            load_s  = 1'b1;
            state_n = ST_RUN;
          end else begin
            state_n = ST_FIN;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          adv_s = 1'b1;
          if (last_s) begin
            state_n = ST_FIN;
          end else begin
            state_n = ST_RUN;
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, beat counter, captured length and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= {(N+1){1'b0}};
      len_r      <= {(N+1){1'b0}};
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == ST_RUN);
      valid_r <= (state_n == ST_RUN);
      done_r  <= (state_n == ST_FIN);
      if (load_s) begin
        beat_cnt_r <= {(N+1){1'b0}};
        len_r      <= len;
      end else if (adv_s) begin
        beat_cnt_r <= beat_cnt_r + {{N{1'b0}}, 1'b1};
        len_r      <= len_r;
      end else begin
        beat_cnt_r <= beat_cnt_r;
        len_r      <= len_r;
      end
    end
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign done      = done_r;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    sa_acc_lane #(.N(N)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s),
      .init_zero (init_zero_s),
      .adv       (adv_s),
      .k_in      (k[c*N +: N]),
      .bit_out   (x_out[c]),
      .ones      (ones_cnt[c*(N+1) +: (N+1)])
    );
  end

endmodule

// File: tb/tb_sa_multi_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_sa_multi_stream_gen
// Directed self-checking bench for sa_multi_stream_gen at N=3, CH=4.
// Expected beat patterns are hand-computed from the overflow-accumulator rule.
// -----------------------------------------------------------------------------
module tb_sa_multi_stream_gen;

  localparam int unsigned N  = 3;
  localparam int unsigned CH = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [N:0]        len;
  logic [CH*N-1:0]   k;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [CH-1:0]     x_out;
  logic              done;
  logic [CH*(N+1)-1:0] ones_cnt;

  int compared = 0;
  int failed   = 0;

  sa_multi_stream_gen #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .k         (k),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected ones_cnt: the counters exist only when the feature is built in
  function automatic logic [15:0] exp_ones(input logic [15:0] v);
`ifdef SA_ONES_CNT_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a stream in IDLE, then scramble inputs to show they were captured
  task automatic start_stream(input logic m, input logic [N:0] l, input logic [CH*N-1:0] kv);
    mode  = m;
    len   = l;
    k     = kv;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = ~m;
    len   = 4'd1;
    k     = 12'hfff;
  endtask

  // Consume nb beats with out_ready high; nibble i of exp is beat i.
  // With poke set, start is held high during RUN (must be ignored).
  task automatic run_beats(input logic [31:0] exp, input int nb, input bit poke);
    out_ready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      chk("valid_in_run", 32'(out_valid), 32'd1);
      chk("busy_in_run", 32'(busy), 32'd1);
      chk($sformatf("x_out_beat%0d", i), 32'(x_out), 32'(exp[i*4 +: 4]));
      start = poke && (i < nb - 1);
      len   = 4'd2;
      tick();
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_in_fin", 32'(out_valid), 32'd0);
    chk("busy_in_fin", 32'(busy), 32'd0);
    // start during the done cycle must be ignored
    start = 1'b1;
    len   = 4'd5;
    tick();
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_fin", 32'(busy), 32'd0);
    tick();
    chk("still_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int bi;
    int cyc;
    logic [15:0] rdy_pat;

    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    len       = 4'd0;
    k         = 12'h000;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ones", 32'(ones_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // SA mode, k=3, len=8: 0,1,0,1,0,0,1,0
    start_stream(1'b0, 4'd8, 12'h003);
    run_beats(32'h01001010, 8, 1'b0);
    chk("ones_sa_k3", 32'(ones_cnt), 32'(exp_ones(16'h0003)));

    // Zero mode, k=3, len=8: 0,0,1,0,0,1,0,1; start poked mid-stream
    start_stream(1'b1, 4'd8, 12'h003);
    run_beats(32'h10100100, 8, 1'b1);
    chk("ones_zero_k3", 32'(ones_cnt), 32'(exp_ones(16'h0003)));

    // Four lanes k = {0,7,4,1} (lane3..lane0), SA mode, len=8
    start_stream(1'b0, 4'd8, {3'd0, 3'd7, 3'd4, 3'd1});
    run_beats(32'h46425646, 8, 1'b0);
    chk("ones_4lane", 32'(ones_cnt), 32'(exp_ones(16'h0741)));

    // Backpressure on the k=3 SA stream: same sequence, stable while stalled
    rdy_pat = 16'b0110_1001_0011_0101;
    start_stream(1'b0, 4'd8, 12'h003);
    bi  = 0;
    cyc = 0;
    while (bi < 8 && cyc < 64) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_x_out", 32'(x_out), 32'((32'h01001010 >> (bi * 4)) & 32'hf));
      out_ready = rdy_pat[cyc % 16];
      tick();
      if (out_ready) bi++;
      cyc++;
    end
    chk("stall_beat_count", 32'(bi), 32'd8);
    chk("stall_done", 32'(done), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("stall_done_low", 32'(done), 32'd0);
    chk("stall_ones", 32'(ones_cnt), 32'(exp_ones(16'h0003)));

    // len = 0: no beats, done one cycle after start
    start_stream(1'b0, 4'd0, 12'h003);
    chk("len0_valid", 32'(out_valid), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_done", 32'(done), 32'd1);
    tick();
    chk("len0_done_low", 32'(done), 32'd0);

    // Reset after 3 beats aborts without done; restart begins from L/2
    start_stream(1'b0, 4'd8, 12'h003);
    for (int i = 0; i < 3; i++) begin
      chk("pre_abort_beat", 32'(x_out), 32'((32'h01001010 >> (i * 4)) & 32'hf));
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    start_stream(1'b0, 4'd8, 12'h003);
    run_beats(32'h01001010, 8, 1'b0);

    // k=5, SA mode, len=4: 1,0,1,1 -> 3 ones
    start_stream(1'b0, 4'd4, 12'h005);
    run_beats(32'h00001101, 4, 1'b0);
    chk("ones_k5_len4", 32'(ones_cnt), 32'(exp_ones(16'h0003)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
